// File: rtl/pll_clk_en_gen.sv
// ---------------------------------------------------------------------------
// pll_clk_en_gen
// Clock-enable generator and reset sequencer sitting behind a PLL output.
// Qualifies PLL lock, holds reset_out until lock has been stable for
// LOCK_CYCLES synchronised cycles, then runs NUM_CH programmable dividers
// producing one-cycle enables and divided waveforms. Ratios are re-programmed
// only at period boundaries, and resync restarts every channel together.
//
// Ports
//   clk_in         clock (PLL output domain)
//   reset_in       synchronous active-high reset
//   pll_locked_in  raw asynchronous PLL lock indication
//   cfg_wr         divide-ratio write strobe
//   cfg_ch         channel index for cfg_wr (indices >= NUM_CH ignored)
//   cfg_div        new divide ratio (0 disables the channel)
//   resync         one-cycle pulse restarting all channel counters
//   cfg_pending    per channel: written ratio not yet active
//   clk_en         per channel: one-cycle enable pulse each period
//   clk_div_out    per channel: divided waveform, high for ceil(D/2) cycles
//   reset_out      active-high reset for the downstream domain
// ---------------------------------------------------------------------------
module pll_clk_en_gen #(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned DIV_W       = 8,
   parameter int unsigned INIT_DIV    = 1,
   parameter int unsigned LOCK_CYCLES = 16,
   localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk_in,
   input  logic              reset_in,
   input  logic              pll_locked_in,
   input  logic              cfg_wr,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic              resync,
   output logic [NUM_CH-1:0] cfg_pending,
   output logic [NUM_CH-1:0] clk_en,
   output logic [NUM_CH-1:0] clk_div_out,
   output logic              reset_out
);

   localparam int unsigned LC_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

   typedef enum logic {
      ST_WAIT   = 1'b0,
      ST_LOCKED = 1'b1
   } lock_state_t;

   // Lock qualification state
   logic [1:0]        r_sync;
   logic              w_lk;
   lock_state_t       r_state;
   logic [LC_W-1:0]   r_lock_cnt;
   logic              r_reset_out;
   logic              w_locked;

   // Channel state
   logic [DIV_W-1:0]  r_div    [NUM_CH];
   logic [DIV_W-1:0]  r_shadow [NUM_CH];
   logic [DIV_W-1:0]  r_cnt    [NUM_CH];
   logic [NUM_CH-1:0] r_pending;
   logic [NUM_CH-1:0] r_clk_en;
   logic [NUM_CH-1:0] r_clk_div;

   // Per-channel decode
   logic              w_cfg_ok;
   logic [NUM_CH-1:0] w_wr_hit;
   logic [NUM_CH-1:0] w_wrap;
   logic [DIV_W-1:0]  w_new_div [NUM_CH];
   logic [DIV_W-1:0]  w_half    [NUM_CH];

   assign w_lk     = r_sync[1];
   assign w_locked = (r_state == ST_LOCKED);
   assign w_cfg_ok = cfg_wr && (32'(cfg_ch) < NUM_CH);

   // Write decode, wrap detect, ratio to load and high-phase length per channel
   always_comb begin
      w_wr_hit = '0;
      w_wrap   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_new_div[i] = r_shadow[i];
         w_half[i]    = '0;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         w_wr_hit[i] = w_cfg_ok && (cfg_ch == CH_W'(i));
         // A write landing on the apply edge takes effect directly
         w_new_div[i] = w_wr_hit[i] ? cfg_div : r_shadow[i];
         w_wrap[i]    = (r_div[i] != '0) && (r_cnt[i] == (r_div[i] - DIV_W'(1)));
         // ceil(D/2) without widening: floor(D/2) plus the odd bit
         w_half[i]    = (r_div[i] >> 1) + DIV_W'(r_div[i][0]);
      end
   end

   // Lock synchroniser, lock-qualification FSM and registered reset_out
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         r_sync      <= '0;
         r_state     <= ST_WAIT;
         r_lock_cnt  <= '0;
         r_reset_out <= 1'b1;
      end else begin
         r_sync      <= {r_sync[0], pll_locked_in};
         r_reset_out <= (r_state != ST_LOCKED);
         case (r_state)
            ST_WAIT: begin
               if (!w_lk) begin
                  r_lock_cnt <= '0;
               end else if (r_lock_cnt == LC_W'(LOCK_CYCLES - 1)) begin
                  r_state    <= ST_LOCKED;
                  r_lock_cnt <= '0;
               end else begin
                  r_lock_cnt <= r_lock_cnt + LC_W'(1);
               end
            end
            ST_LOCKED: begin
               if (!w_lk) begin
                  r_state    <= ST_WAIT;
                  r_lock_cnt <= '0;
               end
            end
            default: begin
               r_state    <= ST_WAIT;
               r_lock_cnt <= '0;
            end
         endcase
      end
   end

   // Divider channels: counters, enables, waveforms and glitch-free ratio update
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_div[i]    <= DIV_W'(INIT_DIV);
            r_shadow[i] <= DIV_W'(INIT_DIV);
            r_cnt[i]    <= '0;
         end
         r_pending <= '0;
         r_clk_en  <= '0;
         r_clk_div <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (w_wr_hit[i]) begin
               r_shadow[i] <= cfg_div;
            end

            if (!w_locked || resync) begin
               // Idle or restart: counters cleared, latest ratio loaded
               r_cnt[i]     <= '0;
               r_clk_en[i]  <= 1'b0;
               r_clk_div[i] <= 1'b0;
               r_div[i]     <= w_new_div[i];
               r_pending[i] <= 1'b0;
            end else if (r_div[i] == '0) begin
               // Disabled channel has no period boundary, so apply on the next edge
               r_cnt[i]     <= '0;
               r_clk_en[i]  <= 1'b0;
               r_clk_div[i] <= 1'b0;
               if (r_pending[i]) begin
                  r_div[i]     <= w_new_div[i];
                  r_pending[i] <= 1'b0;
               end else if (w_wr_hit[i]) begin
                  r_pending[i] <= 1'b1;
               end
            end else begin
               r_clk_en[i]  <= w_wrap[i];
               r_clk_div[i] <= (r_cnt[i] < w_half[i]);
               if (w_wrap[i]) begin
                  r_cnt[i] <= '0;
                  if (r_pending[i] || w_wr_hit[i]) begin
                     r_div[i]     <= w_new_div[i];
                     r_pending[i] <= 1'b0;
                  end
               end else begin
                  r_cnt[i] <= r_cnt[i] + DIV_W'(1);
                  if (w_wr_hit[i]) begin
                     r_pending[i] <= 1'b1;
                  end
               end
            end
         end
      end
   end

   assign cfg_pending = r_pending;
   assign clk_en      = r_clk_en;
   assign clk_div_out = r_clk_div;
   assign reset_out   = r_reset_out;

endmodule

// File: tb/tb_pll_clk_en_gen.sv
// ---------------------------------------------------------------------------
// tb_pll_clk_en_gen
// Scoreboard bench: every clock edge the stimulus side runs a behavioural
// model (lock = run of synchronised highs >= LOCK_CYCLES; channel phase from
// modular arithmetic on an anchor edge) and queues the expected outputs; a
// monitor on the falling edge pops and compares against the DUT.
// ---------------------------------------------------------------------------
module tb_pll_clk_en_gen;

   localparam int unsigned NCH  = 6;
   localparam int unsigned DW   = 8;
   localparam int unsigned INIT = 1;
   localparam int unsigned LC   = 16;
   localparam int unsigned CW   = 3;

   logic           clk = 1'b0;
   logic           reset_in;
   logic           pll;
   logic           cfg_wr;
   logic [CW-1:0]  cfg_ch;
   logic [DW-1:0]  cfg_div;
   logic           resync;
   logic [NCH-1:0] cfg_pending;
   logic [NCH-1:0] clk_en;
   logic [NCH-1:0] clk_div_out;
   logic           reset_out;

   pll_clk_en_gen #(
      .NUM_CH      (NCH),
      .DIV_W       (DW),
      .INIT_DIV    (INIT),
      .LOCK_CYCLES (LC)
   ) dut (
      .clk_in        (clk),
      .reset_in      (reset_in),
      .pll_locked_in (pll),
      .cfg_wr        (cfg_wr),
      .cfg_ch        (cfg_ch),
      .cfg_div       (cfg_div),
      .resync        (resync),
      .cfg_pending   (cfg_pending),
      .clk_en        (clk_en),
      .clk_div_out   (clk_div_out),
      .reset_out     (reset_out)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic           rst;
      logic [NCH-1:0] en;
      logic [NCH-1:0] dout;
      logic [NCH-1:0] pend;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   // Reference model state
   int     m_d      [NCH];
   int     m_sh     [NCH];
   longint m_anchor [NCH];   // edge after which the channel counter was 0
   bit     m_pend   [NCH];
   bit     m_p1, m_p2;       // pll_locked_in as seen one and two edges ago
   int     m_run;            // consecutive synchronised lock-high edges
   longint m_edge = 0;       // index of the next edge

   function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
      end
   endfunction

   // Counter value the model holds just before the next edge
   function automatic int model_cnt(input int i);
      if (m_d[i] == 0) return 0;
      return int'((m_edge - 1 - m_anchor[i]) % longint'(m_d[i]));
   endfunction

   function automatic void model_edge();
      exp_t e;
      bit   locked;
      bit   wr;
      int   nv;
      int   c;
      e = '0;
      if (reset_in) begin
         for (int i = 0; i < NCH; i++) begin
            m_d[i] = INIT; m_sh[i] = INIT; m_anchor[i] = m_edge; m_pend[i] = 1'b0;
         end
         m_p1 = 1'b0; m_p2 = 1'b0; m_run = 0;
         e.rst = 1'b1;
      end else begin
         locked = (m_run >= int'(LC));
         e.rst  = !locked;
         for (int i = 0; i < NCH; i++) begin
            wr = cfg_wr && (int'(cfg_ch) == i);
            nv = wr ? int'(cfg_div) : m_sh[i];
            c  = model_cnt(i);
            if (!locked || resync) begin
               m_d[i] = nv; m_anchor[i] = m_edge; m_pend[i] = 1'b0;
            end else if (m_d[i] == 0) begin
               if (m_pend[i]) begin
                  m_d[i] = nv; m_anchor[i] = m_edge; m_pend[i] = 1'b0;
               end else if (wr) begin
                  m_pend[i] = 1'b1;
               end
            end else begin
               e.en[i]   = (c == m_d[i] - 1);
               e.dout[i] = (2 * c < m_d[i]);
               if (e.en[i]) begin
                  if (m_pend[i] || wr) begin
                     m_d[i] = nv; m_anchor[i] = m_edge; m_pend[i] = 1'b0;
                  end
               end else if (wr) begin
                  m_pend[i] = 1'b1;
               end
            end
            e.pend[i] = m_pend[i];
            if (wr) m_sh[i] = int'(cfg_div);
         end
         m_run = m_p2 ? ((m_run > int'(LC)) ? m_run : m_run + 1) : 0;
         m_p2  = m_p1;
         m_p1  = pll;
      end
      exp_q.push_back(e);
      m_edge++;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // Tick until reset_out reaches lvl; returns the number of edges taken
   task automatic wait_rst(input logic lvl, input int bound, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (reset_out !== lvl && n < bound);
      if (reset_out !== lvl) begin
         n_vec++;
         n_bad++;
         $display("FAIL wait_reset_out: no change after %0d edges, got %b want %b", n, reset_out, lvl);
         n = -1;
      end
   endtask

   task automatic wr1(input int ch, input int dv);
      cfg_wr = 1'b1; cfg_ch = CW'(ch); cfg_div = DW'(dv);
      tick();
      cfg_wr = 1'b0;
   endtask

   // Monitor: compare DUT outputs against the queued expectation each cycle
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("reset_out",   32'(reset_out),   32'(e.rst));
         check("clk_en",      32'(clk_en),      32'(e.en));
         check("clk_div_out", 32'(clk_div_out), 32'(e.dout));
         check("cfg_pending", 32'(cfg_pending), 32'(e.pend));
      end
   end

   initial begin
      int n;
      int low_left;
      logic [2:0] en3;
      reset_in = 1'b1; pll = 1'b0; cfg_wr = 1'b0; cfg_ch = '0; cfg_div = '0; resync = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         m_d[i] = INIT; m_sh[i] = INIT; m_anchor[i] = 0; m_pend[i] = 1'b0;
      end
      m_p1 = 1'b0; m_p2 = 1'b0; m_run = 0;
      tick(); tick();
      reset_in = 1'b0;
      tick();

      // Steady lock: release LOCK_CYCLES+2 edges after the first high sample
      pll = 1'b1;
      wait_rst(1'b0, 40, n);
      check("lock_release_edges", 32'(n - 1), 32'(LC + 2));

      // Glitch during qualification restarts the count
      pll = 1'b0;
      wait_rst(1'b1, 10, n);
      check("lock_loss_edges", 32'(n - 1), 32'd3);
      pll = 1'b1; repeat (10) tick();
      pll = 1'b0; tick();
      pll = 1'b1;
      wait_rst(1'b0, 40, n);
      check("relock_release_edges", 32'(n - 1), 32'(LC + 2));

      // ch0 D=4, ch1 D=3
      wr1(0, 4);
      wr1(1, 3);
      repeat (30) tick();

      // Reprogram ch0 to 2 when its counter is at 1
      n = 0;
      while (model_cnt(0) != 1 && n < 10) begin tick(); n++; end
      wr1(0, 2);
      check("pending_after_write", 32'(cfg_pending[0]), 32'd1);
      repeat (20) tick();

      // Disable ch2, then re-enable with D=5; out-of-range channel writes ignored
      wr1(2, 0);
      repeat (10) tick();
      wr1(2, 5);
      repeat (20) tick();
      wr1(7, 9);
      wr1(6, 2);
      repeat (10) tick();

      // Three D=3 channels at different phases, then resync aligns them
      wr1(0, 3); tick();
      wr1(1, 3); tick(); tick();
      wr1(2, 3);
      repeat (5) tick();
      resync = 1'b1; tick(); resync = 1'b0;
      check("resync_en_zero", 32'(clk_en), 32'd0);
      repeat (3) tick();
      en3 = clk_en[2:0];
      check("resync_align", 32'(en3), 32'h7);
      repeat (6) tick();

      // resync together with a write applies the written ratio at once
      resync = 1'b1; cfg_wr = 1'b1; cfg_ch = 3'd3; cfg_div = 8'd2;
      tick();
      resync = 1'b0; cfg_wr = 1'b0;
      check("resync_wr_not_pending", 32'(cfg_pending[3]), 32'd0);
      repeat (10) tick();

      // Lock loss mid-run
      pll = 1'b0;
      wait_rst(1'b1, 10, n);
      check("midrun_loss_edges", 32'(n - 1), 32'd3);
      check("midrun_loss_en", 32'(clk_en), 32'd0);
      pll = 1'b1;
      wait_rst(1'b0, 40, n);

      // Randomised traffic
      low_left = 0;
      for (int k = 0; k < 900; k++) begin
         if (low_left > 0) begin
            pll = 1'b0; low_left--;
         end else begin
            pll = 1'b1;
            if ($urandom % 250 == 0) low_left = int'($urandom_range(1, 3));
         end
         reset_in = ($urandom % 500 == 0);
         cfg_wr   = ($urandom % 4 == 0);
         cfg_ch   = CW'($urandom_range(0, 7));
         cfg_div  = ($urandom % 8 == 0) ? 8'd0 : DW'($urandom_range(1, 9));
         resync   = ($urandom % 40 == 0);
         tick();
      end
      reset_in = 1'b0; cfg_wr = 1'b0; resync = 1'b0; pll = 1'b1;
      repeat (4) tick();
      @(negedge clk);
      @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
